// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues requests to a variable-latency
// instruction memory, buffers one instruction for IF/ID, and handles redirects.
module instruction_fetch #(
  parameter int              n        = 32,
  parameter logic [n-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         stall_in,
  input  logic         branch_taken_in,
  input  logic [n-1:0] branch_target_in,
  input  logic         jump_in,
  input  logic [n-1:0] jump_target_in,
  output logic         imem_req_out,
  output logic [n-1:0] imem_addr_out,
  input  logic         imem_ready_in,
  input  logic [n-1:0] imem_rdata_in,
  output logic [n-1:0] Instruction_memory_out,
  output logic [n-1:0] PC_counter_output_out,
  output logic         if_valid_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [n-1:0] PC_STEP = n'(4);

  state_t       r_state;
  logic [n-1:0] r_pc;
  logic [n-1:0] r_redirect_pc;
  logic [n-1:0] r_instr;
  logic [n-1:0] r_pc4;
  logic         r_valid;

  state_t       w_state_nxt;
  logic [n-1:0] w_pc_nxt;
  logic [n-1:0] w_redirect_pc_nxt;
  logic [n-1:0] w_instr_nxt;
  logic [n-1:0] w_pc4_nxt;
  logic         w_valid_nxt;

  logic         w_redirect;
  logic [n-1:0] w_target;
  logic         w_req;
  logic [n-1:0] w_pc_plus4;

  // Branch has priority over jump when both are asserted.
  assign w_redirect = branch_taken_in | jump_in;
  assign w_target   = branch_taken_in ? branch_target_in : jump_target_in;
  assign w_pc_plus4 = r_pc + PC_STEP;

  // The request cannot drop while pending: the buffer only changes on ready,
  // so the issue condition stays true until the memory answers.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_RUN:   w_req = ~r_valid | ~stall_in;
      S_DRAIN: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  assign imem_req_out           = w_req;
  assign imem_addr_out          = r_pc;
  assign Instruction_memory_out = r_instr;
  assign PC_counter_output_out  = r_pc4;
  assign if_valid_out           = r_valid;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_redirect_pc_nxt = r_redirect_pc;
    w_instr_nxt       = r_instr;
    w_pc4_nxt         = r_pc4;
    w_valid_nxt       = r_valid;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_RUN;
        w_valid_nxt = 1'b0;
      end
      S_RUN: begin
        if (w_redirect) begin
          w_valid_nxt = 1'b0;
          if (w_req && !imem_ready_in) begin
            w_redirect_pc_nxt = w_target;
            w_state_nxt       = S_DRAIN;
          end else begin
            w_pc_nxt = w_target;
          end
        end else if (w_req && imem_ready_in) begin
          w_instr_nxt = imem_rdata_in;
          w_pc4_nxt   = w_pc_plus4;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_plus4;
        end else if (r_valid && !stall_in) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        w_valid_nxt = 1'b0;
        if (w_redirect) begin
          w_redirect_pc_nxt = w_target;
        end
        if (imem_ready_in) begin
          w_pc_nxt    = w_redirect ? w_target : r_redirect_pc;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_redirect_pc <= '0;
      r_instr       <= '0;
      r_pc4         <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_pc4         <= w_pc4_nxt;
      r_valid       <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: start-up, stall, redirects, DRAIN,
// priority, latest-wins, mid-fetch reset and PC wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        stall_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        jump_in;
  logic [31:0] jump_target_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] Instruction_memory_out;
  logic [31:0] PC_counter_output_out;
  logic        if_valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: instruction word is the address XOR a fixed tag.
  assign imem_rdata_in = imem_addr_out ^ 32'hDEAD_0000;

  instruction_fetch #(.n(32), .RESET_PC(32'h0000_0000)) dut (
    .clk                    (clk),
    .reset_in               (reset_in),
    .stall_in               (stall_in),
    .branch_taken_in        (branch_taken_in),
    .branch_target_in       (branch_target_in),
    .jump_in                (jump_in),
    .jump_target_in         (jump_target_in),
    .imem_req_out           (imem_req_out),
    .imem_addr_out          (imem_addr_out),
    .imem_ready_in          (imem_ready_in),
    .imem_rdata_in          (imem_rdata_in),
    .Instruction_memory_out (Instruction_memory_out),
    .PC_counter_output_out  (PC_counter_output_out),
    .if_valid_out           (if_valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_in = 1'b1; stall_in = 1'b0; imem_ready_in = 1'b1;
    branch_taken_in = 1'b0; branch_target_in = '0;
    jump_in = 1'b0; jump_target_in = '0;
    tick(); tick();
    settle();
    chk("rst_req",   {31'b0, imem_req_out}, 32'd0);
    chk("rst_valid", {31'b0, if_valid_out}, 32'd0);
    chk("rst_instr", Instruction_memory_out, 32'h0);
    chk("rst_pc4",   PC_counter_output_out,  32'h0);

    // Cycle 0 after release: IDLE, no request.
    reset_in = 1'b0; settle();
    chk("c0_req", {31'b0, imem_req_out}, 32'd0);
    tick(); settle();
    chk("c1_req",  {31'b0, imem_req_out}, 32'd1);
    chk("c1_addr", imem_addr_out, 32'h0);
    tick(); settle();
    chk("c2_valid", {31'b0, if_valid_out}, 32'd1);
    chk("c2_pc4",   PC_counter_output_out, 32'h4);
    chk("c2_instr", Instruction_memory_out, 32'hDEAD_0000);
    chk("c2_addr",  imem_addr_out, 32'h4);
    tick(); settle();
    chk("c3_pc4",  PC_counter_output_out, 32'h8);
    chk("c3_addr", imem_addr_out, 32'h8);
    tick(); settle();
    chk("c4_pc4",   PC_counter_output_out, 32'hC);
    chk("c4_instr", Instruction_memory_out, 32'hDEAD_0008);

    // Stall three cycles with the 0x8 instruction buffered.
    stall_in = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",   {31'b0, imem_req_out}, 32'd0);
      chk("stall_addr",  imem_addr_out, 32'hC);
      chk("stall_pc4",   PC_counter_output_out, 32'hC);
      chk("stall_valid", {31'b0, if_valid_out}, 32'd1);
      if (i < 2) begin tick(); settle(); end
    end
    tick();
    stall_in = 1'b0; settle();
    chk("unstall_req",  {31'b0, imem_req_out}, 32'd1);
    chk("unstall_addr", imem_addr_out, 32'hC);
    tick(); settle();
    chk("adv_pc4",   PC_counter_output_out, 32'h10);
    chk("adv_instr", Instruction_memory_out, 32'hDEAD_000C);

    // Redirect during a memory wait on 0x10.
    imem_ready_in = 1'b0; settle();
    chk("wait0_addr", imem_addr_out, 32'h10);
    tick();
    branch_taken_in = 1'b1; branch_target_in = 32'h100; settle();
    chk("wait1_req",   {31'b0, imem_req_out}, 32'd1);
    chk("wait1_addr",  imem_addr_out, 32'h10);
    chk("wait1_valid", {31'b0, if_valid_out}, 32'd0);
    tick();
    branch_taken_in = 1'b0; settle();
    chk("drain_req",   {31'b0, imem_req_out}, 32'd1);
    chk("drain_addr",  imem_addr_out, 32'h10);
    chk("drain_valid", {31'b0, if_valid_out}, 32'd0);
    tick();
    imem_ready_in = 1'b1; settle();
    chk("drain_rdy_addr", imem_addr_out, 32'h10);
    tick(); settle();
    chk("redir_valid", {31'b0, if_valid_out}, 32'd0);
    chk("redir_addr",  imem_addr_out, 32'h100);
    chk("redir_req",   {31'b0, imem_req_out}, 32'd1);
    tick(); settle();
    chk("redir_pc4",   PC_counter_output_out, 32'h104);
    chk("redir_instr", Instruction_memory_out, 32'hDEAD_0100);

    // Zero-wait redirect to 0x20, then jump coincident with ready on 0x20.
    branch_taken_in = 1'b1; branch_target_in = 32'h20; settle();
    tick();
    branch_taken_in = 1'b0; settle();
    chk("b20_valid", {31'b0, if_valid_out}, 32'd0);
    chk("b20_addr",  imem_addr_out, 32'h20);
    jump_in = 1'b1; jump_target_in = 32'h40; settle();
    tick();
    jump_in = 1'b0; settle();
    chk("j40_valid", {31'b0, if_valid_out}, 32'd0);
    chk("j40_addr",  imem_addr_out, 32'h40);
    tick(); settle();
    chk("j40_pc4",   PC_counter_output_out, 32'h44);
    chk("j40_instr", Instruction_memory_out, 32'hDEAD_0040);

    // Branch beats jump when both assert.
    branch_taken_in = 1'b1; branch_target_in = 32'h200;
    jump_in = 1'b1; jump_target_in = 32'h300; settle();
    tick();
    branch_taken_in = 1'b0; jump_in = 1'b0; settle();
    chk("prio_addr", imem_addr_out, 32'h200);

    // Latest redirect wins during DRAIN.
    imem_ready_in = 1'b0; settle();
    tick();
    branch_taken_in = 1'b1; branch_target_in = 32'h300; settle();
    tick();
    branch_taken_in = 1'b0; jump_in = 1'b1; jump_target_in = 32'h400; settle();
    chk("lw_addr", imem_addr_out, 32'h200);
    chk("lw_req",  {31'b0, imem_req_out}, 32'd1);
    tick();
    jump_in = 1'b0; settle();
    chk("lw_drain_addr", imem_addr_out, 32'h200);
    imem_ready_in = 1'b1; settle();
    tick(); settle();
    chk("lw_resume_addr", imem_addr_out, 32'h400);
    chk("lw_valid",       {31'b0, if_valid_out}, 32'd0);
    tick(); settle();
    chk("lw_pc4", PC_counter_output_out, 32'h404);

    // Reset while in DRAIN.
    imem_ready_in = 1'b0; branch_taken_in = 1'b1; branch_target_in = 32'h500; settle();
    tick();
    branch_taken_in = 1'b0; settle();
    chk("pre_rst_addr", imem_addr_out, 32'h404);
    reset_in = 1'b1; imem_ready_in = 1'b1; settle();
    chk("mid_rst_req",   {31'b0, imem_req_out}, 32'd0);
    chk("mid_rst_valid", {31'b0, if_valid_out}, 32'd0);
    chk("mid_rst_pc4",   PC_counter_output_out, 32'h0);
    tick(); tick();
    reset_in = 1'b0; settle();
    chk("mr_c0_req", {31'b0, imem_req_out}, 32'd0);
    tick(); settle();
    chk("mr_c1_req",  {31'b0, imem_req_out}, 32'd1);
    chk("mr_c1_addr", imem_addr_out, 32'h0);
    tick(); settle();
    chk("mr_c2_pc4", PC_counter_output_out, 32'h4);

    // PC wrap at the top of the address space.
    branch_taken_in = 1'b1; branch_target_in = 32'hFFFF_FFFC; settle();
    tick();
    branch_taken_in = 1'b0; settle();
    chk("wrap_addr", imem_addr_out, 32'hFFFF_FFFC);
    tick(); settle();
    chk("wrap_pc4",   PC_counter_output_out, 32'h0);
    chk("wrap_instr", Instruction_memory_out, 32'h2152_FFFC);
    chk("wrap_next",  imem_addr_out, 32'h0);

    // Redirect while stalled flushes the buffer.
    stall_in = 1'b1; branch_taken_in = 1'b1; branch_target_in = 32'h80; settle();
    chk("sr_req", {31'b0, imem_req_out}, 32'd0);
    tick();
    branch_taken_in = 1'b0; settle();
    chk("sr_valid", {31'b0, if_valid_out}, 32'd0);
    chk("sr_addr",  imem_addr_out, 32'h80);
    chk("sr_req2",  {31'b0, imem_req_out}, 32'd1);
    stall_in = 1'b0; settle();
    tick(); settle();
    chk("sr_pc4", PC_counter_output_out, 32'h84);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
